// File: rtl/shift_reg_sequencer.sv
// Command-stream generator for the 4-bit universal shift register.
// Emits one registered control word per clock so the register ends up holding a captured target word.
module shift_reg_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_word,
    output logic [7:0]       o_ctrl,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_PAR = 2'b00,
        MODE_SR  = 2'b01,
        MODE_SL  = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

    state_e           state, state_nxt;
    mode_e            mode_q, mode_nxt;
    logic [WIDTH-1:0] word_q, word_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [7:0]       ctrl_nxt;
    logic             busy_nxt, done_nxt;

    // Word k of a sequence. Shift-right feeds LSB first through the MSB input,
    // shift-left feeds MSB first through the LSB input.
    function automatic logic [7:0] cmd_word(input mode_e mode, input logic [WIDTH-1:0] w,
                                            input logic [CW-1:0] k);
        logic [CW-1:0] rk;
        rk = LAST - k;
        case (mode)
            MODE_PAR: cmd_word = {2'b01, 2'b00, w};
            MODE_SR:  cmd_word = {2'b11, w[k], 1'b0, 4'h0};
            MODE_SL:  cmd_word = {2'b10, 1'b0, w[rk], 4'h0};
            default:  cmd_word = {2'b01, 2'b00, 4'h0};
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        word_nxt  = word_q;
        cnt_nxt   = cnt;
        ctrl_nxt  = 8'h00;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            // A request in the DONE cycle is accepted, leaving exactly one hold word between sequences.
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (i_start) begin
                    state_nxt = EMIT;
                    mode_nxt  = mode_e'(i_mode);
                    word_nxt  = i_word;
                    cnt_nxt   = '0;
                    ctrl_nxt  = cmd_word(mode_e'(i_mode), i_word, '0);
                    busy_nxt  = 1'b1;
                end
            end
            EMIT: begin
                if (mode_q == MODE_PAR || mode_q == MODE_CLR || cnt == LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    ctrl_nxt = cmd_word(mode_q, word_q, cnt + 1'b1);
                    busy_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            mode_q <= MODE_PAR;
            word_q <= '0;
            cnt    <= '0;
            o_ctrl <= 8'h00;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_nxt;
            mode_q <= mode_nxt;
            word_q <= word_nxt;
            cnt    <= cnt_nxt;
            o_ctrl <= ctrl_nxt;
            o_busy <= busy_nxt;
            o_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer: expected command streams are hand-computed,
// and a small universal shift register model confirms the final register contents.
module tb_shift_reg_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [1:0] i_mode;
    logic [3:0] i_word;
    logic [7:0] o_ctrl;
    logic       o_busy;
    logic       o_done;

    int checks = 0;
    int errors = 0;
    logic [3:0] mdl = 4'h0;

    logic [7:0] exp_sr [4] = '{8'hE0, 8'hE0, 8'hC0, 8'hE0};
    logic [7:0] exp_sl [4] = '{8'h80, 8'h90, 8'h90, 8'h80};

    shift_reg_sequencer #(.WIDTH(4)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_mode  (i_mode),
        .i_word  (i_word),
        .o_ctrl  (o_ctrl),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] c, input logic b, input logic d);
        chk({tag, ".ctrl"}, 32'(o_ctrl), 32'(c));
        chk({tag, ".busy"}, 32'(o_busy), 32'(b));
        chk({tag, ".done"}, 32'(o_done), 32'(d));
    endtask

    // Register model consuming one control word
    task automatic apply_model(input logic [7:0] c);
        case (c[7:6])
            2'b01:   mdl = c[3:0];
            2'b10:   mdl = {mdl[2:0], c[4]};
            2'b11:   mdl = {c[5], mdl[3:1]};
            default: mdl = mdl;
        endcase
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b1;
        i_mode  = 2'b00;
        i_word  = 4'hF;

        // Reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("rst%0d", i), 8'h00, 1'b0, 1'b0);
        end
        i_rst   = 1'b0;
        i_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out($sformatf("idle%0d", i), 8'h00, 1'b0, 1'b0);
        end

        // Parallel load
        i_mode = 2'b00; i_word = 4'hA; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk_out("par.w0", 8'h4A, 1'b1, 1'b0);
        apply_model(o_ctrl);
        tick();
        chk_out("par.done", 8'h00, 1'b0, 1'b1);
        tick();
        chk_out("par.idle", 8'h00, 1'b0, 1'b0);
        chk("par.model", 32'(mdl), 32'hA);

        // Serial right, input word changed after capture
        mdl = 4'h0;
        i_mode = 2'b01; i_word = 4'b1011; i_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            i_start = 1'b0;
            i_word  = 4'h0;
            i_mode  = 2'b00;
            chk_out($sformatf("sr.w%0d", k), exp_sr[k], 1'b1, 1'b0);
            apply_model(o_ctrl);
        end
        tick();
        chk_out("sr.done", 8'h00, 1'b0, 1'b1);
        chk("sr.model", 32'(mdl), 32'hB);
        tick();
        chk_out("sr.idle", 8'h00, 1'b0, 1'b0);

        // Serial left
        mdl = 4'h0;
        i_mode = 2'b10; i_word = 4'b0110; i_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            i_start = 1'b0;
            chk_out($sformatf("sl.w%0d", k), exp_sl[k], 1'b1, 1'b0);
            apply_model(o_ctrl);
        end
        tick();
        chk_out("sl.done", 8'h00, 1'b0, 1'b1);
        chk("sl.model", 32'(mdl), 32'h6);
        tick();

        // Overlap: starts during EMIT ignored, start during DONE accepted
        i_mode = 2'b01; i_word = 4'b1011; i_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            i_mode  = 2'b00;
            i_word  = 4'hF;
            i_start = (k < 3);
            chk_out($sformatf("ov.w%0d", k), exp_sr[k], 1'b1, 1'b0);
        end
        tick();
        chk_out("ov.done", 8'h00, 1'b0, 1'b1);
        i_mode = 2'b11; i_word = 4'h9; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk_out("ov.clr", 8'h40, 1'b1, 1'b0);
        tick();
        chk_out("ov.clrdone", 8'h00, 1'b0, 1'b1);
        tick();
        chk_out("ov.idle", 8'h00, 1'b0, 1'b0);

        // Abort mid-sequence
        i_mode = 2'b10; i_word = 4'b0110; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk_out("ab.w0", 8'h80, 1'b1, 1'b0);
        tick();
        chk_out("ab.w1", 8'h90, 1'b1, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk_out("ab.rst", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("ab.quiet%0d", i), 8'h00, 1'b0, 1'b0);
        end
        i_mode = 2'b00; i_word = 4'h5; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk_out("ab.par", 8'h45, 1'b1, 1'b0);
        tick();
        chk_out("ab.pardone", 8'h00, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
